pipe_ctrl_chain: RTL
====================

Name: pipe_ctrl_chain

Overview:
- Parametrised multi-stage pipeline register chain for control and data bundles. Successor to the fixed 8-bit decode-to-execute control register.
- Adds per-stage valid bits, per-stage stall with backpressure, per-stage flush with bubble insertion, and occupancy tracking.
- Sits between decode and writeback. One instance replaces the chain of fixed per-stage control registers.

Parameters:
- WIDTH, 8: bits of payload per stage (one bit per control signal).
- DEPTH, 3: number of register stages (>=1).
- BUBBLE, '0: payload value forced into any invalid stage. Write-enable bits are 0, so a bubble is a NOP.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  payload from the producing stage.
- valid_i  input  1  payload on data_i is a real instruction.
- stall_i  input  DEPTH  stall_i[k] freezes stage k.
- flush_i  input  DEPTH  flush_i[k] converts stage k to a bubble.
- in_ready_o  output  1  stage 0 will capture this cycle.
- data_o  output  WIDTH  payload of stage DEPTH-1.
- valid_o  output  1  valid bit of stage DEPTH-1.
- stage_valid_o  output  DEPTH  valid bit of each stage.
- occupancy_o  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush):
  - every stage payload = BUBBLE and valid = 0.
  - occupancy_o = 0 and valid_o = 0.
  - in_ready_o = 1 once reset deasserts, provided stall_i = 0.
- Hold chain (combinational):
  - hold[DEPTH-1] = stall_i[DEPTH-1].
  - hold[k] = stall_i[k] | hold[k+1] for k < DEPTH-1.
  - A stall anywhere freezes that stage and every stage upstream of it.
- in_ready_o = ~hold[0]. Purely combinational from stall_i; flush_i does not affect it.
- Per-stage next state, priority flush > hold > advance:
  - flush_i[k]=1: payload <= BUBBLE, valid <= 0, even if hold[k] is set.
  - else hold[k]=1: payload and valid unchanged.
  - else k=0: payload <= valid_i ? data_i : BUBBLE, valid <= valid_i.
  - else k>0, hold[k-1]=1: payload <= BUBBLE, valid <= 0. A bubble is inserted behind the frozen upstream stage.
  - else k>0: stage k takes stage k-1's payload and valid.
- Latency: an unstalled valid input appears on data_o/valid_o exactly DEPTH rising edges after capture.
- Payload masking: data_o equals BUBBLE whenever valid_o = 0. No stale payload is ever visible.
- Input loss: valid_i with in_ready_o=0 is not captured. The producer must hold it. With in_ready_o=1 and flush_i[0]=1 the input is dropped.
- occupancy_o:
  - registered, equal to popcount(stage_valid_o) every cycle.
  - range 0..DEPTH, never wraps.
- Simultaneous events:
  - flush of a stage while the downstream stage is stalled: the flushed stage becomes a bubble, the downstream stage keeps its content.
  - stall_i all-ones: whole chain frozen, in_ready_o=0.
  - flush_i all-ones: every stage becomes a bubble next edge, regardless of stall.
- DEPTH=1: degenerates to a single register with enable and clear.

Decomposition:
- Package pipe_pkg:
  - ctrl_t packed struct {alu_src, branch, alu_ctrl[1:0], mem_write, mem_to_reg, reg_dest, reg_write} (8 bits).
  - CTRL_BUBBLE constant (all zero).
  - function popcount for occupancy.
- Sub-module pipe_stage: one WIDTH payload register plus valid bit with flush/hold/load inputs and BUBBLE parameter, async active-high reset. pipe_ctrl_chain instantiates DEPTH copies in a generate loop and computes the hold chain.

Test Plan (WIDTH=8, DEPTH=3, BUBBLE=8'h00):
- Reset mid-stream: load 8'hA5, 8'h3C, then assert reset between edges -> outputs change immediately to data_o=00, valid_o=0, occupancy_o=0, with no clock edge needed.
- Streaming: valid_i=1 with data 01,02,03,04 on consecutive cycles, no stall -> data_o shows 01 on the 3rd edge after capture, then 02,03,04 back-to-back; occupancy_o climbs 1,2,3 and holds at 3.
- Mid-stall bubble: chain full {03,02,01}, stall_i=3'b010 for 2 cycles:
  - stage 2 drains 01 and then takes a bubble; stage 0 and stage 1 hold.
  - in_ready_o=0, and valid_i=1 with data 04 is not captured.
  - occupancy_o goes 3 then 2.
  - after release, 02 appears next.
- Flush priority: stage 1 holds 8'h55, stall_i[1]=1 and flush_i[1]=1 same cycle -> stage_valid_o[1]=0 next edge and 55 never reaches data_o.
- Input flush: valid_i=1, data 8'hFF, flush_i[0]=1 -> stage 0 stays a bubble, in_ready_o=1, FF never appears, occupancy unchanged.
- All-ones: stall_i=3'b111 plus flush_i=3'b111 with a full chain -> all stages are bubbles next edge, occupancy_o=0, data_o=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the control pipeline register chain.
package pipe_pkg;

    // Decode-to-execute control bundle, one bit per control signal.
    typedef struct packed {
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_ctrl;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dest;
        logic       reg_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // All write enables low, so an injected bubble behaves as a NOP.
    localparam ctrl_t CTRL_BUBBLE = 8'h00;

    // Number of set bits; used to derive the occupancy count.
    function automatic logic [31:0] popcount(input logic [31:0] vec);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake/data bundle between the producer/controller and the chain.
interface pipe_ctrl_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic [DEPTH-1:0] stall_i;
    logic [DEPTH-1:0] flush_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic [DEPTH-1:0] stage_valid_o;
    logic [OCC_W-1:0] occupancy_o;

    modport master (
        output data_i, valid_i, stall_i, flush_i,
        input  in_ready_o, data_o, valid_o, stage_valid_o, occupancy_o
    );

    modport slave (
        input  data_i, valid_i, stall_i, flush_i,
        output in_ready_o, data_o, valid_o, stage_valid_o, occupancy_o
    );
endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: payload register plus valid bit.
// Priority is flush > hold > load; an invalid stage always carries BUBBLE.
module pipe_stage #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             valid_nxt
);

    logic [WIDTH-1:0] data_nxt;

    // Next-state selection for payload and valid bit.
    always_comb begin
        data_nxt  = data;
        valid_nxt = valid;
        if (flush) begin
            data_nxt  = BUBBLE;
            valid_nxt = 1'b0;
        end else if (hold) begin
            data_nxt  = data;
            valid_nxt = valid;
        end else if (in_valid) begin
            data_nxt  = in_data;
            valid_nxt = 1'b1;
        end else begin
            data_nxt  = BUBBLE;
            valid_nxt = 1'b0;
        end
    end

    // Stage register with asynchronous clear to a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= BUBBLE;
            valid <= 1'b0;
        end else begin
            data  <= data_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Parametrised control/data pipeline chain with per-stage stall, flush,
// bubble insertion and registered occupancy count.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               DEPTH  = 3,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    pipe_ctrl_chain_if.slave    bus
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0] occ_r;

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        hold            = {DEPTH{1'b0}};
        hold[DEPTH-1]   = bus.stall_i[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = bus.stall_i[k] | hold[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] in_data;
        logic             in_valid;

        if (k == 0) begin : g_head
            assign in_data  = bus.data_i;
            assign in_valid = bus.valid_i;
        end else begin : g_body
            // A frozen upstream stage hands a bubble downstream.
            assign in_data  = stage_data[k-1];
            assign in_valid = stage_valid[k-1] & ~hold[k-1];
        end

        pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (bus.flush_i[k]),
            .hold      (hold[k]),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .data      (stage_data[k]),
            .valid     (stage_valid[k]),
            .valid_nxt (valid_nxt[k])
        );
    end

    // Occupancy tracks the popcount of the valid bits being loaded this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            occ_r <= OCC_W'(popcount(32'(valid_nxt)));
        end
    end

    assign bus.in_ready_o    = ~hold[0];
    assign bus.data_o        = stage_data[DEPTH-1];
    assign bus.valid_o       = stage_valid[DEPTH-1];
    assign bus.stage_valid_o = stage_valid;
    assign bus.occupancy_o   = occ_r;

endmodule
